seq_detect_prog: RTL and testbench
==================================

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the match counter.
REQ-003 Parameter RST_PAT, default 8'b0000_1101; RST_LEN, default 4; RST_OVL, default 1: configuration loaded at reset.
REQ-004 clk  input  1  clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_bit is presented this cycle.
REQ-007 in_bit  input  1  serial data bit.
REQ-008 cfg_load  input  1  latch the cfg_* inputs this cycle.
REQ-009 cfg_pattern  input  PAT_W  pattern, right-aligned; bit [len-1] is the first bit received.
REQ-010 cfg_len  input  $clog2(PAT_W+1)  pattern length in bits.
REQ-011 cfg_overlap  input  1  1 = overlapping matches allowed.
REQ-012 cnt_clr  input  1  clear match_cnt.
REQ-013 match  output  1  registered one-cycle pulse per detected pattern.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.
REQ-015 cfg_err  output  1  one-cycle pulse when a cfg_load is rejected.

Function
REQ-016 History: on an accepted bit, hist SHALL become {hist[PAT_W-2:0], in_bit}, and fill SHALL become min(fill+1, PAT_W); in_valid=0 SHALL hold hist and fill.
REQ-017 Detection: a bit is a completing bit when it is accepted, the new fill >= len, and the new hist[len-1:0] == pat[len-1:0]; bits above len SHALL be ignored.
REQ-018 match SHALL be 1 exactly in the cycle after a completing bit (latency 1) and 0 otherwise.
REQ-019 Overlap=1: hist and fill SHALL be unaffected by a match, so suffix/prefix overlaps match.
REQ-020 Overlap=0: on a completing bit, fill SHALL be set to 0, so no bit participates in two matches.
REQ-021 cfg_load with 2 <= cfg_len <= PAT_W: pat, len and overlap SHALL be latched, and fill SHALL be cleared; match_cnt SHALL be unchanged.
REQ-022 cfg_load with cfg_len < 2 or cfg_len > PAT_W: the previous configuration and fill SHALL be retained, and cfg_err SHALL pulse in the next cycle.
REQ-023 cfg_load together with in_valid: the configuration action wins and in_bit SHALL be discarded; this applies even when the load is rejected.
REQ-024 match_cnt SHALL increment on each completing bit and saturate at 2^CNT_W-1.
REQ-025 cnt_clr SHALL set match_cnt to 0 next cycle; cnt_clr together with a completing bit SHALL give 0, while match still pulses.

Reset
REQ-026 rst SHALL set: hist=0, fill=0, pat=RST_PAT, len=RST_LEN, overlap=RST_OVL, match=0, match_cnt=0, cfg_err=0.
REQ-027 rst SHALL override all other inputs in the same cycle, including mid-pattern; partial history SHALL be lost.

Structure
REQ-028 Package seq_det_pkg SHALL hold the default PAT_W/CNT_W/RST_* constants and the length-legality function.
REQ-029 The saturating counter with clear SHALL be the sub-module seq_det_sat_cnt; all other logic SHALL be in seq_detect_prog.

Verification
REQ-030 Default configuration (1101, overlap), bits 1,1,0,1,1,0,1 -> match after the 4th and 7th bits; match_cnt=2.
REQ-031 cfg_load 1101, len 4, overlap=0; same stream -> match after the 4th bit only; match_cnt=1.
REQ-032 cfg_load 0xA5, len 8; bits 1,0,1,0,0,1,0,1 with in_valid gaps of 0-3 cycles -> single match 1 cycle after the 8th accepted bit.
REQ-033 cfg_load with cfg_len=0, then with cfg_len=9 -> cfg_err pulses each time; the 1101 stream still matches.
REQ-034 CNT_W=2, 5 matches -> match_cnt stays at 3; cnt_clr coincident with a completing bit -> match=1, match_cnt=0.
REQ-035 Bits 1,1,0, then rst for 1 cycle, then bit 1 -> no match; match_cnt=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int          DEF_PAT_W   = 8;
  localparam int          DEF_CNT_W   = 16;
  localparam logic [31:0] DEF_RST_PAT = 32'h0000_000D;
  localparam int          DEF_RST_LEN = 4;
  localparam bit          DEF_RST_OVL = 1'b1;

  // A pattern shorter than two bits is meaningless; longer than PAT_W cannot be held.
  function automatic logic len_ok(input int len, input int pat_w);
    return (len >= 2) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Bit stream, configuration and result bundle of the pattern detector.
interface seq_detect_prog_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  match, match_cnt, cfg_err
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match, match_cnt, cfg_err
  );

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module seq_det_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: shifts accepted bits into a history and
// flags each completion of the configured pattern, optionally without overlap.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = DEF_PAT_W,
  parameter int             CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
  parameter int             RST_LEN = DEF_RST_LEN,
  parameter bit             RST_OVL = DEF_RST_OVL
) (
  input logic              clk,
  input logic              rst,
  seq_detect_prog_if.slave bus
);

  localparam int               LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] FULL  = LEN_W'(PAT_W);

  // The oldest history bit falls off on the next shift, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic [LEN_W-1:0] fill;
  logic             match_r;
  logic             cfg_err_r;

  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_inc;
  logic             accept;
  logic             cfg_ok;
  logic             complete;

  always_comb begin
    accept   = bus.in_valid && !bus.cfg_load;
    cfg_ok   = len_ok(int'(bus.cfg_len), PAT_W);
    hist_nxt = {hist, bus.in_bit};
    fill_inc = (fill == FULL) ? fill : fill + LEN_W'(1);
    mask     = ~({PAT_W{1'b1}} << len);
    complete = accept && (fill_inc >= len) && ((hist_nxt & mask) == (pat & mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= RST_PAT;
      len       <= LEN_W'(RST_LEN);
      ovl       <= RST_OVL;
      match_r   <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      match_r   <= complete;
      cfg_err_r <= bus.cfg_load && !cfg_ok;
      // A load in the same cycle as a bit wins, even if the load is rejected.
      if (bus.cfg_load) begin
        if (cfg_ok) begin
          pat  <= bus.cfg_pattern;
          len  <= bus.cfg_len;
          ovl  <= bus.cfg_overlap;
          fill <= '0;
        end
      end else if (bus.in_valid) begin
        hist <= hist_nxt[PAT_W-2:0];
        fill <= (complete && !ovl) ? '0 : fill_inc;
      end
    end
  end

  seq_det_sat_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (complete),
    .cnt (bus.match_cnt)
  );

  assign bus.match   = match_r;
  assign bus.cfg_err = cfg_err_r;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: a queue-based reference model predicts
// every cycle's outputs for a 16-bit and a 2-bit counter instance.
module tb_seq_detect_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_detect_prog_if #(.PAT_W(8), .CNT_W(16)) bus ();
  seq_detect_prog_if #(.PAT_W(8), .CNT_W(2))  bus2 ();

  assign bus2.in_valid    = bus.in_valid;
  assign bus2.in_bit      = bus.in_bit;
  assign bus2.cfg_load    = bus.cfg_load;
  assign bus2.cfg_pattern = bus.cfg_pattern;
  assign bus2.cfg_len     = bus.cfg_len;
  assign bus2.cfg_overlap = bus.cfg_overlap;
  assign bus2.cnt_clr     = bus.cnt_clr;

  seq_detect_prog #(.PAT_W(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  seq_detect_prog #(.PAT_W(8), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int due;
    bit m;
    bit e;
    int c16;
    int c2;
  } exp_t;
  exp_t sb[$];

  // reference model state
  bit         m_hist[$];
  int         m_fill = 0;
  logic [7:0] m_pat  = 8'h0D;
  int         m_len  = 4;
  bit         m_ovl  = 1'b1;
  int         m_cnt  = 0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit b, input bit ld,
                       input logic [7:0] p, input logic [3:0] l, input bit o, input bit c);
    exp_t e;
    bit   hit;
    @(posedge clk);
    #1;
    rst             = r;
    bus.in_valid    = v;
    bus.in_bit      = b;
    bus.cfg_load    = ld;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    bus.cnt_clr     = c;
    e.due = cyc + 1;
    e.m   = 1'b0;
    e.e   = 1'b0;
    if (r) begin
      m_hist.delete();
      m_fill = 0;
      m_pat  = 8'h0D;
      m_len  = 4;
      m_ovl  = 1'b1;
      m_cnt  = 0;
    end else begin
      if (ld) begin
        if (int'(l) >= 2 && int'(l) <= 8) begin
          m_pat  = p;
          m_len  = int'(l);
          m_ovl  = o;
          m_fill = 0;
        end else begin
          e.e = 1'b1;
        end
      end else if (v) begin
        m_hist.push_back(b);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        m_fill = min_i(m_fill + 1, 8);
        hit = (m_fill >= m_len);
        if (hit) begin
          // most recent bit pairs with pat[0], the one before with pat[1], ...
          for (int i = 0; i < m_len; i++)
            if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
        if (hit) begin
          e.m = 1'b1;
          m_cnt++;
          if (!m_ovl) m_fill = 0;
        end
      end
      if (c) m_cnt = 0;
    end
    e.c16 = min_i(m_cnt, 65535);
    e.c2  = min_i(m_cnt, 3);
    sb.push_back(e);
  endtask

  task automatic bit_in(input bit b);
    drive(1'b0, 1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    drive(1'b0, 1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
  endtask

  task automatic clr_cnt();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic stream_1101101();
    bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0); bit_in(1);
  endtask

  task automatic peek_cnt(input string name, input int exp16, input int exp2);
    @(posedge clk);
    #2;
    chk({name, "_cnt16"}, int'(bus.match_cnt), exp16);
    chk({name, "_cnt2"}, int'(bus2.match_cnt), exp2);
  endtask

  // monitor: compare every predicted cycle once its edge has passed
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("match", int'(bus.match), int'(e.m));
        chk("match_w2", int'(bus2.match), int'(e.m));
        chk("cfg_err", int'(bus.cfg_err), int'(e.e));
        chk("cnt16", int'(bus.match_cnt), e.c16);
        chk("cnt2", int'(bus2.match_cnt), e.c2);
      end
    end
  end

  initial begin
    bit [7:0] a5;
    bus.in_valid    = 1'b0;
    bus.in_bit      = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = 8'h00;
    bus.cfg_len     = 4'd0;
    bus.cfg_overlap = 1'b0;
    bus.cnt_clr     = 1'b0;

    do_reset();
    do_reset();
    idle();
    peek_cnt("reset", 0, 0);

    // default 1101 with overlap
    stream_1101101();
    idle();
    peek_cnt("ovl", 2, 2);

    // 1101 without overlap
    clr_cnt();
    load(8'h0D, 4'd4, 1'b0);
    stream_1101101();
    idle();
    peek_cnt("no_ovl", 1, 1);

    // 0xA5 over 8 bits with random gaps
    clr_cnt();
    load(8'hA5, 4'd8, 1'b1);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      bit_in(a5[i]);
      repeat ($urandom_range(0, 3)) idle();
    end
    idle();
    peek_cnt("a5_gaps", 1, 1);

    // illegal lengths are rejected and leave 1101 in place
    clr_cnt();
    load(8'h0D, 4'd4, 1'b1);
    load(8'hFF, 4'd0, 1'b0);
    load(8'hFF, 4'd9, 1'b0);
    stream_1101101();
    idle();
    peek_cnt("bad_len", 2, 2);

    // saturation of the 2-bit counter, then clear racing a completion
    do_reset();
    bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    repeat (4) begin
      bit_in(1); bit_in(0); bit_in(1);
    end
    idle();
    peek_cnt("sat", 5, 3);
    bit_in(1); bit_in(0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    idle();
    peek_cnt("clr_hit", 0, 0);

    // reset mid-pattern discards partial history
    bit_in(1); bit_in(1); bit_in(0);
    do_reset();
    bit_in(1);
    idle();
    peek_cnt("rst_mid", 0, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int unsigned r;
      logic [3:0]  l;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else if (r < 8) begin
        if ($urandom_range(0, 3) == 0) l = 4'($urandom_range(0, 15));
        else                           l = 4'($urandom_range(2, 5));
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
              8'($urandom), l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      end else begin
        drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
              8'h00, 4'd0, 1'b0, 1'($urandom_range(0, 59) == 0));
      end
    end

    repeat (3) idle();
    @(posedge clk);
    #5;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
